// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the 3-digit 1A2B guessing game
//               controller and its VGA text overlay.
//               - state_t   : controller state encoding
//               - digit_t   : one BCD entry digit
//               - ASCII_*   : characters used by the overlay ("xA yB")
//               - entry_valid(): digit range + distinctness check
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;
  localparam int DIGIT_MAX  = 9;

  // Characters the overlay prints next to the score fields.
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_B    = 8'h42;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    SCORE = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } state_t;

  // An entry is usable only if every digit is decimal and no digit repeats;
  // distinctness is what lets the scorer avoid double counting.
  function automatic logic entry_valid(input digit_t d1, input digit_t d2,
                                       input digit_t d3);
    logic in_range;
    logic distinct;
    in_range = (d1 <= digit_t'(DIGIT_MAX)) && (d2 <= digit_t'(DIGIT_MAX)) &&
               (d3 <= digit_t'(DIGIT_MAX));
    distinct = (d1 != d2) && (d1 != d3) && (d2 != d3);
    return in_range && distinct;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ab_scorer.sv
`default_nettype none
// ============================================================================
// Module      : ab_scorer
// Description : Purely combinational 1A2B scorer. Compares a 3-digit guess
//               against the 3-digit secret.
//               a = digits equal in the same position
//               b = digits present in the secret but at another position
// Ports       : i_guess1..3  in  DIGIT_W  guess digits (hundreds..units)
//               i_secret1..3 in  DIGIT_W  secret digits (hundreds..units)
//               o_a          out 2        right digit, right place
//               o_b          out 2        right digit, wrong place
// Revision    : 1.0 - initial release
// ============================================================================
module ab_scorer
  import game_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_guess1,
  input  logic [DIGIT_W-1:0] i_guess2,
  input  logic [DIGIT_W-1:0] i_guess3,
  input  logic [DIGIT_W-1:0] i_secret1,
  input  logic [DIGIT_W-1:0] i_secret2,
  input  logic [DIGIT_W-1:0] i_secret3,
  output logic [1:0]         o_a,
  output logic [1:0]         o_b
);

  digit_t w_guess  [NUM_DIGITS];
  digit_t w_secret [NUM_DIGITS];
  logic [1:0] w_a;
  logic [1:0] w_b;

  assign w_guess[0]  = i_guess1;
  assign w_guess[1]  = i_guess2;
  assign w_guess[2]  = i_guess3;
  assign w_secret[0] = i_secret1;
  assign w_secret[1] = i_secret2;
  assign w_secret[2] = i_secret3;

  // With distinct digits each guess digit matches at most one secret digit,
  // so a+b <= 3 and the 2-bit accumulators cannot overflow.
  always_comb begin
    w_a = 2'd0;
    w_b = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (w_guess[i] == w_secret[j]) begin
          if (i == j) w_a = w_a + 2'd1;
          else        w_b = w_b + 2'd1;
        end
      end
    end
  end

  assign o_a = w_a;
  assign o_b = w_b;

endmodule
`default_nettype wire

// File: rtl/guess_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : guess_game_ctrl
// Description : Sequencer for the 3-digit 1A2B guessing game. The first valid
//               entry after IDLE is the secret; later entries are guesses that
//               are scored one cycle later. Tracks attempts and declares WIN
//               or LOSE. Feeds the text overlay only.
// Parameters  : MAX_GUESS  guesses allowed before LOSE (1..15)
//               CNT_W      guess counter width, must hold MAX_GUESS
// Ports       : clk         in   1      system clock
//               reset       in   1      asynchronous active-low reset
//               iNum1..3    in   4      entered digits (hundreds..units)
//               iNumRdy     in   1      entry-valid level, taken on 0->1 only
//               iNewGame    in   1      pulse: abandon game, back to IDLE
//               oStarted    out  1      secret held
//               oA / oB     out  2      bulls / cows of last scored guess
//               oGuess1..3  out  4      last accepted guess
//               oScoreVld   out  1      a guess has been scored this game
//               oGuessCnt   out  CNT_W  guesses scored this game
//               oReject     out  1      pulse: entry refused
//               oWin/oLose  out  1      game result levels
// Revision    : 1.0 - initial release
// ============================================================================
module guess_game_ctrl
  import game_pkg::*;
#(
  parameter int MAX_GUESS = 10,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] iNum1,
  input  logic [DIGIT_W-1:0] iNum2,
  input  logic [DIGIT_W-1:0] iNum3,
  input  logic               iNumRdy,
  input  logic               iNewGame,
  output logic               oStarted,
  output logic [1:0]         oA,
  output logic [1:0]         oB,
  output logic [DIGIT_W-1:0] oGuess1,
  output logic [DIGIT_W-1:0] oGuess2,
  output logic [DIGIT_W-1:0] oGuess3,
  output logic               oScoreVld,
  output logic [CNT_W-1:0]   oGuessCnt,
  output logic               oReject,
  output logic               oWin,
  output logic               oLose
);

  localparam logic [CNT_W-1:0] c_max_guess = CNT_W'(MAX_GUESS);

  state_t r_state;
  state_t w_state_nxt;

  logic             r_rdy_q;
  digit_t           r_secret1, r_secret2, r_secret3;
  digit_t           r_guess1, r_guess2, r_guess3;
  logic [1:0]       r_a, r_b;
  logic             r_started;
  logic             r_score_vld;
  logic [CNT_W-1:0] r_cnt;
  logic             r_reject;
  logic             r_win;
  logic             r_lose;

  logic             w_take;
  logic             w_valid;
  logic             w_accepting;
  logic [1:0]       w_a, w_b;
  logic [CNT_W-1:0] w_cnt_inc;

  // Rising-edge detect: a keypad level held high yields a single take.
  assign w_take      = iNumRdy & ~r_rdy_q;
  assign w_valid     = entry_valid(iNum1, iNum2, iNum3);
  // Only IDLE and PLAY look at takes; SCORE silently drops them and the
  // terminal states ignore them without a reject.
  assign w_accepting = (r_state == IDLE) || (r_state == PLAY);

  // Counter never wraps past MAX_GUESS.
  assign w_cnt_inc = (r_cnt >= c_max_guess) ? r_cnt : r_cnt + CNT_W'(1);

  ab_scorer u_ab_scorer (
    .i_guess1  (r_guess1),
    .i_guess2  (r_guess2),
    .i_guess3  (r_guess3),
    .i_secret1 (r_secret1),
    .i_secret2 (r_secret2),
    .i_secret3 (r_secret3),
    .o_a       (w_a),
    .o_b       (w_b)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // Next-state logic; iNewGame overrides anything else this cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (iNewGame) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (w_take && w_valid) w_state_nxt = PLAY;
        PLAY:  if (w_take && w_valid) w_state_nxt = SCORE;
        SCORE: begin
          if (w_a == 2'd3)                   w_state_nxt = WIN;
          else if (w_cnt_inc == c_max_guess) w_state_nxt = LOSE;
          else                               w_state_nxt = PLAY;
        end
        WIN:     w_state_nxt = WIN;
        LOSE:    w_state_nxt = LOSE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath / output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdy_q     <= 1'b0;
      r_secret1   <= '0;
      r_secret2   <= '0;
      r_secret3   <= '0;
      r_guess1    <= '0;
      r_guess2    <= '0;
      r_guess3    <= '0;
      r_a         <= 2'd0;
      r_b         <= 2'd0;
      r_started   <= 1'b0;
      r_score_vld <= 1'b0;
      r_cnt       <= '0;
      r_reject    <= 1'b0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
    end else begin
      r_rdy_q  <= iNumRdy;
      r_reject <= 1'b0;
      if (iNewGame) begin
        r_secret1   <= '0;
        r_secret2   <= '0;
        r_secret3   <= '0;
        r_guess1    <= '0;
        r_guess2    <= '0;
        r_guess3    <= '0;
        r_a         <= 2'd0;
        r_b         <= 2'd0;
        r_started   <= 1'b0;
        r_score_vld <= 1'b0;
        r_cnt       <= '0;
        r_win       <= 1'b0;
        r_lose      <= 1'b0;
      end else begin
        if (w_take && w_accepting && !w_valid) r_reject <= 1'b1;

        case (r_state)
          IDLE: begin
            if (w_take && w_valid) begin
              r_secret1 <= iNum1;
              r_secret2 <= iNum2;
              r_secret3 <= iNum3;
              r_started <= 1'b1;
            end
          end
          PLAY: begin
            if (w_take && w_valid) begin
              r_guess1 <= iNum1;
              r_guess2 <= iNum2;
              r_guess3 <= iNum3;
            end
          end
          SCORE: begin
            r_a         <= w_a;
            r_b         <= w_b;
            r_score_vld <= 1'b1;
            r_cnt       <= w_cnt_inc;
            if (w_a == 2'd3)                   r_win  <= 1'b1;
            else if (w_cnt_inc == c_max_guess) r_lose <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign oStarted  = r_started;
  assign oA        = r_a;
  assign oB        = r_b;
  assign oGuess1   = r_guess1;
  assign oGuess2   = r_guess2;
  assign oGuess3   = r_guess3;
  assign oScoreVld = r_score_vld;
  assign oGuessCnt = r_cnt;
  assign oReject   = r_reject;
  assign oWin      = r_win;
  assign oLose     = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_guess_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_guess_game_ctrl
// Description : Self-checking bench for guess_game_ctrl. A game-level model
//               predicts every output each cycle; directed scenarios add
//               literal expectations for scores, rejects, win/lose, new game
//               and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_game_ctrl;

  localparam int MAXG = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] n1 = 4'd0, n2 = 4'd0, n3 = 4'd0;
  logic       rdy = 1'b0;
  logic       ng = 1'b0;

  logic       oStarted, oScoreVld, oReject, oWin, oLose;
  logic [1:0] oA, oB;
  logic [3:0] oGuess1, oGuess2, oGuess3;
  logic [3:0] oGuessCnt;

  always #5 clk = ~clk;

  guess_game_ctrl #(.MAX_GUESS(MAXG), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .iNum1     (n1),
    .iNum2     (n2),
    .iNum3     (n3),
    .iNumRdy   (rdy),
    .iNewGame  (ng),
    .oStarted  (oStarted),
    .oA        (oA),
    .oB        (oB),
    .oGuess1   (oGuess1),
    .oGuess2   (oGuess2),
    .oGuess3   (oGuess3),
    .oScoreVld (oScoreVld),
    .oGuessCnt (oGuessCnt),
    .oReject   (oReject),
    .oWin      (oWin),
    .oLose     (oLose)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Game-level model: what a player would see after each clock.
  // --------------------------------------------------------------------------
  int m_prev, m_have_secret, m_pending, m_over, m_take, m_ok, m_common;
  int m_sec [3];
  int m_gu  [3];
  int m_in  [3];
  int e_started, e_a, e_b, e_vld, e_cnt, e_rej, e_win, e_lose;

  task automatic model_clear();
    m_have_secret = 0; m_pending = 0; m_over = 0;
    for (int i = 0; i < 3; i++) begin m_sec[i] = 0; m_gu[i] = 0; end
    e_started = 0; e_a = 0; e_b = 0; e_vld = 0; e_cnt = 0;
    e_rej = 0; e_win = 0; e_lose = 0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_clear();
      m_prev = 0;
    end else begin
      m_take = (rdy == 1'b1 && m_prev == 0) ? 1 : 0;
      m_prev = (rdy == 1'b1) ? 1 : 0;
      m_in[0] = int'(n1); m_in[1] = int'(n2); m_in[2] = int'(n3);
      m_ok = (m_in[0] < 10 && m_in[1] < 10 && m_in[2] < 10 &&
              m_in[0] != m_in[1] && m_in[0] != m_in[2] &&
              m_in[1] != m_in[2]) ? 1 : 0;
      e_rej = 0;
      if (ng == 1'b1) begin
        model_clear();
      end else if (m_pending != 0) begin
        // Scoring cycle: any take now is lost.
        m_pending = 0;
        e_a = 0; m_common = 0;
        for (int i = 0; i < 3; i++) begin
          if (m_gu[i] == m_sec[i]) e_a++;
          for (int j = 0; j < 3; j++) if (m_gu[i] == m_sec[j]) m_common++;
        end
        e_b = m_common - e_a;
        e_vld = 1;
        if (e_cnt < MAXG) e_cnt++;
        if (e_a == 3) begin e_win = 1; m_over = 1; end
        else if (e_cnt == MAXG) begin e_lose = 1; m_over = 1; end
      end else if (m_over == 0 && m_take != 0) begin
        if (m_ok == 0) e_rej = 1;
        else if (m_have_secret == 0) begin
          for (int i = 0; i < 3; i++) m_sec[i] = m_in[i];
          m_have_secret = 1;
          e_started = 1;
        end else begin
          for (int i = 0; i < 3; i++) m_gu[i] = m_in[i];
          m_pending = 1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("started",  int'(oStarted),  e_started);
      check("a",        int'(oA),        e_a);
      check("b",        int'(oB),        e_b);
      check("guess1",   int'(oGuess1),   m_gu[0]);
      check("guess2",   int'(oGuess2),   m_gu[1]);
      check("guess3",   int'(oGuess3),   m_gu[2]);
      check("scorevld", int'(oScoreVld), e_vld);
      check("cnt",      int'(oGuessCnt), e_cnt);
      check("reject",   int'(oReject),   e_rej);
      check("win",      int'(oWin),      e_win);
      check("lose",     int'(oLose),     e_lose);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all driven on the falling edge)
  // --------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle rdy pulse; returns when a resulting score is visible.
  task automatic enter(input int a, input int b, input int c);
    @(negedge clk);
    n1 = 4'(a); n2 = 4'(b); n3 = 4'(c); rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic new_game();
    @(negedge clk); ng = 1'b1;
    @(negedge clk); ng = 1'b0;
  endtask

  // Entry that must be refused: reject high for exactly one cycle.
  task automatic try_reject(input int a, input int b, input int c, input string name);
    @(negedge clk);
    n1 = 4'(a); n2 = 4'(b); n3 = 4'(c); rdy = 1'b1;
    @(negedge clk);
    check({name, "_pulse"}, int'(oReject), 1);
    rdy = 1'b0;
    @(negedge clk);
    check({name, "_end"}, int'(oReject), 0);
  endtask

  initial begin
    #1 chk_en = 1'b1;

    // T1: rearm / single take on a held level
    cyc(2);
    check("rst_started", int'(oStarted), 0);
    check("rst_cnt", int'(oGuessCnt), 0);
    reset = 1'b1;
    cyc(1);
    n1 = 4'd1; n2 = 4'd2; n3 = 4'd3; rdy = 1'b1;
    cyc(5);
    check("t1_started", int'(oStarted), 1);
    check("t1_one_take_cnt", int'(oGuessCnt), 0);
    rdy = 1'b0;
    cyc(1);
    enter(4, 5, 6);
    check("t1_a", int'(oA), 0);
    check("t1_b", int'(oB), 0);
    check("t1_cnt", int'(oGuessCnt), 1);
    check("t1_vld", int'(oScoreVld), 1);

    // T2: scoring patterns and win
    new_game();
    enter(1, 2, 3);
    enter(1, 3, 2);
    check("t2_132_a", int'(oA), 1); check("t2_132_b", int'(oB), 2);
    enter(3, 1, 2);
    check("t2_312_a", int'(oA), 0); check("t2_312_b", int'(oB), 3);
    enter(1, 2, 9);
    check("t2_129_a", int'(oA), 2); check("t2_129_b", int'(oB), 0);
    enter(1, 2, 3);
    check("t2_123_a", int'(oA), 3); check("t2_win", int'(oWin), 1);
    check("t2_cnt", int'(oGuessCnt), 4);
    enter(4, 5, 6);
    check("t2_after_cnt", int'(oGuessCnt), 4);
    check("t2_after_guess1", int'(oGuess1), 1);
    check("t2_after_rej", int'(oReject), 0);

    // T3: rejects
    new_game();
    try_reject(4, 4, 4, "t3_secret444");
    check("t3_idle_started", int'(oStarted), 0);
    enter(1, 2, 3);
    try_reject(5, 5, 7, "t3_557");
    check("t3_cnt", int'(oGuessCnt), 0);
    try_reject(1, 10, 2, "t3_digit10");
    check("t3_cnt2", int'(oGuessCnt), 0);

    // T4: lose after MAXG misses
    new_game();
    enter(1, 2, 3);
    repeat (MAXG - 1) enter(4, 5, 6);
    check("t4_cnt9", int'(oGuessCnt), MAXG - 1);
    check("t4_lose_early", int'(oLose), 0);
    enter(4, 5, 6);
    check("t4_lose", int'(oLose), 1);
    check("t4_cnt", int'(oGuessCnt), MAXG);
    check("t4_win", int'(oWin), 0);

    // T5: new game beats a simultaneous take
    new_game();
    enter(1, 2, 3);
    enter(4, 5, 6);
    @(negedge clk);
    n1 = 4'd7; n2 = 4'd8; n3 = 4'd9; rdy = 1'b1; ng = 1'b1;
    @(negedge clk);
    ng = 1'b0; rdy = 1'b0;
    check("t5_started", int'(oStarted), 0);
    check("t5_cnt", int'(oGuessCnt), 0);
    check("t5_vld", int'(oScoreVld), 0);
    check("t5_guess1", int'(oGuess1), 0);
    cyc(1);
    enter(7, 8, 9);
    check("t5_new_secret", int'(oStarted), 1);
    enter(1, 2, 3);
    check("t5_score_a", int'(oA), 0);
    check("t5_score_win", int'(oWin), 0);
    check("t5_score_cnt", int'(oGuessCnt), 1);

    // T6: asynchronous reset while scoring
    new_game();
    enter(1, 2, 3);
    enter(1, 3, 2);
    @(negedge clk);
    n1 = 4'd3; n2 = 4'd2; n3 = 4'd1; rdy = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_started", int'(oStarted), 0);
    check("t6_cnt", int'(oGuessCnt), 0);
    check("t6_vld", int'(oScoreVld), 0);
    check("t6_a", int'(oA), 0);
    check("t6_b", int'(oB), 0);
    check("t6_guess2", int'(oGuess2), 0);
    @(negedge clk);
    rdy = 1'b0;
    reset = 1'b1;
    cyc(1);
    enter(1, 2, 3);
    check("t6_restart", int'(oStarted), 1);
    check("t6_restart_cnt", int'(oGuessCnt), 0);

    cyc(2);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
